// File: rtl/direction_queue.sv
// Button-to-direction front end: 2-flop sync, per-button debounce, press-edge detect,
// legality filter and a DEPTH-entry turn FIFO drained one entry per game tick.
module direction_queue #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         DEPTH           = 4,
    parameter logic [3:0] INIT_DIR        = 4'b1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               btn,
    input  logic                     tick,
    output logic [3:0]               direction,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     queue_full,
    output logic                     dropped
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW:0]   DEPTH_CNT = DEPTH[PW:0];
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    level_q, level_d;
    logic [3:0]    level_prev_q;
    logic [3:0]    press_q, press_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [3:0]    dir_q, dir_d;
    logic          dropped_q, dropped_d;

    logic [3:0]    cand;
    logic [3:0]    ref_dir;
    logic [3:0]    opp_dir;
    logic          legal, full, pop, push;

    // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        press_d = level_q & ~level_prev_q;
    end

    // Only one press is evaluated per cycle: up > down > left > right.
    always_comb begin
        cand = 4'b0000;
        if (press_q[0])      cand = 4'b0001;
        else if (press_q[3]) cand = 4'b1000;
        else if (press_q[2]) cand = 4'b0100;
        else if (press_q[1]) cand = 4'b0010;
    end

    // Opposite direction is the bit-reversal of the one-hot code (up<->down, left<->right).
    always_comb begin
        ref_dir = (count_q != '0) ? mem_q[wr_ptr_q - PW'(1)] : dir_q;
        opp_dir = {ref_dir[0], ref_dir[1], ref_dir[2], ref_dir[3]};
        legal   = (cand != 4'b0000) && (cand != ref_dir) && (cand != opp_dir);
        full    = (count_q == DEPTH_CNT);
        pop     = tick && (count_q != '0);
        push    = legal && (!full || pop);
    end

    // tick pops the pre-edge head; a same-cycle push never bypasses into direction.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dir_d     = dir_q;
        dropped_d = legal && full && !pop;
        if (push) begin
            mem_d[wr_ptr_q] = cand;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            dir_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            press_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dir_q     <= INIT_DIR;
            dropped_q <= 1'b0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            dropped_q <= dropped_d;
        end
    end

    assign direction   = dir_q;
    assign queue_count = count_q;
    assign queue_full  = full;
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_direction_queue.sv
// Directed bench for direction_queue: every change of the observable state is checked
// against an expected-snapshot queue filled by the stimulus process.
module tb_direction_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic       tick = 1'b0;
    logic [3:0] direction;
    logic [2:0] queue_count;
    logic       queue_full;
    logic       dropped;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] prev_snap;
    logic [8:0] mon_exp;
    logic       mon_en = 1'b0;
    wire  [8:0] snap = {direction, queue_count, queue_full, dropped};

    direction_queue #(
        .DEBOUNCE_CYCLES(4),
        .DEPTH(4),
        .INIT_DIR(4'b1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .tick(tick),
        .direction(direction),
        .queue_count(queue_count),
        .queue_full(queue_full),
        .dropped(dropped)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // snapshot = {direction, queue_count, queue_full, dropped}
    function automatic logic [8:0] mk(input logic [3:0] d, input int c, input logic drop);
        return {d, 3'(c), (c == 4), drop};
    endfunction

    task automatic expect_st(input logic [3:0] d, input int c, input logic drop);
        exp_q.push_back(mk(d, c, drop));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // driver tasks: inputs change 1 time unit after a rising edge
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] m);
        btn = m;
        cycles(10);
        btn = 4'b0000;
        cycles(10);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cycles(1);
        tick = 1'b0;
        cycles(2);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(2);
    endtask

    // monitor: any change of the observable state consumes one expected snapshot
    always @(negedge clk) begin
        if (mon_en && (snap !== prev_snap)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: got %b want no change from %b", snap, prev_snap);
            end else begin
                mon_exp = exp_q.pop_front();
                if (snap !== mon_exp) begin
                    bad++;
                    $display("FAIL state_seq: got %b want %b", snap, mon_exp);
                end
            end
            prev_snap = snap;
        end
    end

    initial begin
        // reset and idle
        cycles(3);
        check("rst_direction", direction, 4'b1000);
        check("rst_count", queue_count, 0);
        check("rst_full", queue_full, 0);
        check("rst_dropped", dropped, 0);
        rst = 1'b1;
        cycles(2);
        prev_snap = snap;
        mon_en    = 1'b1;
        repeat (10) do_tick();
        check("idle_direction", direction, 4'b1000);

        // debounce: 3-cycle glitch is ignored
        btn = 4'b0100;
        cycles(3);
        btn = 4'b0000;
        cycles(12);
        check("glitch_count", queue_count, 0);

        // debounce latency: write visible exactly 7 edges after first sample
        expect_st(4'b1000, 1, 1'b0);
        btn = 4'b0100;
        cycles(7);
        check("latency_before", queue_count, 0);
        cycles(1);
        check("latency_at", queue_count, 1);
        cycles(50);
        check("held_once", queue_count, 1);
        btn = 4'b0000;
        cycles(10);
        expect_st(4'b0100, 0, 1'b0);
        do_tick();
        check("debounce_tick_dir", direction, 4'b0100);

        // legality from reset (down)
        expect_st(4'b1000, 0, 1'b0);
        pulse_reset();
        press(4'b0001);
        press(4'b1000);
        check("illegal_count", queue_count, 0);
        expect_st(4'b1000, 1, 1'b0);
        press(4'b0100);
        press(4'b0010);
        expect_st(4'b1000, 2, 1'b0);
        press(4'b0001);
        expect_st(4'b0100, 1, 1'b0);
        do_tick();
        expect_st(4'b0001, 0, 1'b0);
        do_tick();

        // overflow
        expect_st(4'b1000, 0, 1'b0);
        pulse_reset();
        expect_st(4'b1000, 1, 1'b0);
        press(4'b0100);
        expect_st(4'b1000, 2, 1'b0);
        press(4'b0001);
        expect_st(4'b1000, 3, 1'b0);
        press(4'b0010);
        expect_st(4'b1000, 4, 1'b0);
        press(4'b1000);
        check("full_flag", queue_full, 1);
        expect_st(4'b1000, 4, 1'b1);
        expect_st(4'b1000, 4, 1'b0);
        press(4'b0100);
        expect_st(4'b0100, 3, 1'b0);
        do_tick();
        expect_st(4'b0001, 2, 1'b0);
        do_tick();
        expect_st(4'b0010, 1, 1'b0);
        do_tick();
        expect_st(4'b1000, 0, 1'b0);
        do_tick();

        // simultaneous presses
        press(4'b0101);
        check("simul_up_left", queue_count, 0);
        expect_st(4'b1000, 1, 1'b0);
        press(4'b0110);
        expect_st(4'b0100, 0, 1'b0);
        do_tick();

        // concurrency: fill, then legal push coinciding with tick on a full queue
        expect_st(4'b0100, 1, 1'b0);
        press(4'b0001);
        expect_st(4'b0100, 2, 1'b0);
        press(4'b0100);
        expect_st(4'b0100, 3, 1'b0);
        press(4'b1000);
        expect_st(4'b0100, 4, 1'b0);
        press(4'b0010);
        expect_st(4'b0001, 4, 1'b0);
        btn = 4'b0001;
        cycles(7);
        tick = 1'b1;
        cycles(1);
        tick = 1'b0;
        check("full_pushpop_dir", direction, 4'b0001);
        check("full_pushpop_count", queue_count, 4);
        cycles(2);
        check("full_pushpop_dropped", dropped, 0);
        btn = 4'b0000;
        cycles(10);
        expect_st(4'b0100, 3, 1'b0);
        do_tick();

        // asynchronous reset with entries queued
        expect_st(4'b1000, 0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_dir", direction, 4'b1000);
        check("async_rst_count", queue_count, 0);
        check("async_rst_full", queue_full, 0);
        cycles(2);
        rst = 1'b1;
        cycles(5);

        check("exp_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
